// File: rtl/mode_select_n.sv
// N-way mode selector driven by two debounced push-buttons, with optional wrap,
// auto-repeat on hold and an up+down chord that returns to RESET_MODE.
module mode_select_n #(
  parameter int NUM_MODES       = 4,
  parameter int RESET_MODE      = 0,
  parameter int WRAP            = 0,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 4,
  localparam int MODE_W = ($clog2(NUM_MODES) < 1) ? 1 : $clog2(NUM_MODES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              idle,
  input  logic              btn_up,
  input  logic              btn_dwn,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic              locked
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [MODE_W-1:0] MODE_MAX  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_HOME = MODE_W'(RESET_MODE);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0]  RPT_FIRST = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0]  RPT_NEXT  = RPT_W'(REPEAT_RATE - 1);

  // state    | meaning: IDLE_REL | no accepted hold; HELD_UP/HELD_DN | one button
  // held after its step, repeat timer running; CHORD | wait for both to release
  typedef enum logic [1:0] {IDLE_REL, HELD_UP, HELD_DN, CHORD} hold_t;

  logic [1:0]        raw, sync1, sync2, db, db_q, rise;
  logic [DB_W-1:0]   db_cnt [2];
  hold_t             state, state_nxt;
  logic [MODE_W-1:0] mode_nxt;
  logic [RPT_W-1:0]  rpt_cnt, rpt_nxt;
  logic              enabled, chord, press_up, press_dn, held_lvl, rpt_due;

  assign raw     = {btn_dwn, btn_up};
  assign locked  = start | ~idle;
  assign enabled = ~locked;

  // Index 0 is the up button, index 1 the down button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise     = db & ~db_q;
  assign chord    = enabled & db[0] & db[1] & (rise[0] | rise[1]);
  assign press_up = enabled & rise[0] & ~db[1];
  assign press_dn = enabled & rise[1] & ~db[0];
  assign held_lvl = (state == HELD_UP) ? db[0] : db[1];
  assign rpt_due  = (REPEAT_DELAY > 0) && (rpt_cnt == '0);

  function automatic logic [MODE_W-1:0] step_up(input logic [MODE_W-1:0] m);
    logic [MODE_W-1:0] r;
    if (m == MODE_MAX) r = (WRAP != 0) ? '0 : m;
    else               r = m + 1'b1;
    return r;
  endfunction

  function automatic logic [MODE_W-1:0] step_dn(input logic [MODE_W-1:0] m);
    logic [MODE_W-1:0] r;
    if (m == '0) r = (WRAP != 0) ? MODE_MAX : m;
    else         r = m - 1'b1;
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    rpt_nxt   = rpt_cnt;
    case (state)
      IDLE_REL: begin
        if (chord) begin
          state_nxt = CHORD;
          mode_nxt  = MODE_HOME;
        end else if (press_up) begin
          state_nxt = HELD_UP;
          mode_nxt  = step_up(mode);
          rpt_nxt   = RPT_FIRST;
        end else if (press_dn) begin
          state_nxt = HELD_DN;
          mode_nxt  = step_dn(mode);
          rpt_nxt   = RPT_FIRST;
        end
      end
      HELD_UP, HELD_DN: begin
        if (locked) begin
          state_nxt = IDLE_REL;
          rpt_nxt   = '0;
        end else if (chord) begin
          state_nxt = CHORD;
          mode_nxt  = MODE_HOME;
          rpt_nxt   = '0;
        end else if (!held_lvl) begin
          // The other button may be pressed in the very cycle this one releases.
          if (press_up) begin
            state_nxt = HELD_UP;
            mode_nxt  = step_up(mode);
            rpt_nxt   = RPT_FIRST;
          end else if (press_dn) begin
            state_nxt = HELD_DN;
            mode_nxt  = step_dn(mode);
            rpt_nxt   = RPT_FIRST;
          end else begin
            state_nxt = IDLE_REL;
            rpt_nxt   = '0;
          end
        end else if (rpt_due) begin
          mode_nxt = (state == HELD_UP) ? step_up(mode) : step_dn(mode);
          rpt_nxt  = RPT_NEXT;
        end else if (REPEAT_DELAY > 0) begin
          rpt_nxt = rpt_cnt - 1'b1;
        end
      end
      CHORD: begin
        if (!db[0] && !db[1]) state_nxt = IDLE_REL;
      end
      default: state_nxt = IDLE_REL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE_REL;
      mode         <= MODE_HOME;
      mode_changed <= 1'b0;
      rpt_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      mode         <= mode_nxt;
      mode_changed <= (mode_nxt != mode);
      rpt_cnt      <= rpt_nxt;
    end
  end

endmodule

// File: tb/tb_mode_select_n.sv
// Bench for mode_select_n: three instances (saturating, wrapping, auto-repeat)
// share stimulus and are compared every cycle against a behavioural model.
module tb_mode_select_n;

  localparam int NM  = 5;
  localparam int DEB = 2;
  localparam int RR  = 4;

  logic       clk, rst, start, idle, btn_up, btn_dwn;
  logic [2:0] mode_b, mode_w, mode_r;
  logic       chg_b, chg_w, chg_r, lk_b, lk_w, lk_r;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int pulses = 0;
  int t0 = 0;
  int rpt_log[$];

  // Behavioural model state; index k: 0 saturating, 1 wrapping, 2 auto-repeat.
  int m_mode[3];
  int m_hold[3];   // 0 released, 1 up held, 2 down held, 3 chord
  int m_p[3];      // edge of the press step of the current hold
  bit m_chg[3];
  bit s1[2], s2[2], db_cur[2], db_old[2];
  bit hist_u[$], hist_d[$];
  int p_wrap[3] = '{0, 1, 0};
  int p_rd[3]   = '{0, 0, 8};

  mode_select_n #(.NUM_MODES(NM), .RESET_MODE(0), .WRAP(0), .DEBOUNCE_CYCLES(DEB),
                  .REPEAT_DELAY(0), .REPEAT_RATE(RR)) u_base (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .btn_up(btn_up),
    .btn_dwn(btn_dwn), .mode(mode_b), .mode_changed(chg_b), .locked(lk_b));

  mode_select_n #(.NUM_MODES(NM), .RESET_MODE(0), .WRAP(1), .DEBOUNCE_CYCLES(DEB),
                  .REPEAT_DELAY(0), .REPEAT_RATE(RR)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .btn_up(btn_up),
    .btn_dwn(btn_dwn), .mode(mode_w), .mode_changed(chg_w), .locked(lk_w));

  mode_select_n #(.NUM_MODES(NM), .RESET_MODE(0), .WRAP(0), .DEBOUNCE_CYCLES(DEB),
                  .REPEAT_DELAY(8), .REPEAT_RATE(RR)) u_rpt (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .btn_up(btn_up),
    .btn_dwn(btn_dwn), .mode(mode_r), .mode_changed(chg_r), .locked(lk_r));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int up_of(int m, int wr);
    if (wr != 0) return (m + 1) % NM;
    return (m + 1 < NM) ? m + 1 : NM - 1;
  endfunction

  function automatic int dn_of(int m, int wr);
    if (wr != 0) return (m + NM - 1) % NM;
    return (m > 0) ? m - 1 : 0;
  endfunction

  // Level flips once the last DEB synchronised samples all disagree with it.
  function automatic bit deb_next(bit cur, bit q[$]);
    if (q.size() < DEB) return cur;
    foreach (q[i]) if (q[i] == cur) return cur;
    return ~cur;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      s1[b] = 0; s2[b] = 0; db_cur[b] = 0; db_old[b] = 0;
    end
    hist_u.delete();
    hist_d.delete();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_chg[k] = 0; m_hold[k] = 0; m_p[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit lvl[2];
    bit rise[2];
    bit lk, en, chord, pu, pd;
    int old, nx, d;
    lk = start | ~idle;
    en = !lk;
    for (int b = 0; b < 2; b++) begin
      lvl[b]  = db_cur[b];
      rise[b] = db_cur[b] & ~db_old[b];
    end
    chord = en && lvl[0] && lvl[1] && (rise[0] || rise[1]);
    pu    = en && rise[0] && !lvl[1];
    pd    = en && rise[1] && !lvl[0];
    for (int k = 0; k < 3; k++) begin
      old = m_mode[k];
      nx  = old;
      case (m_hold[k])
        0: begin
          if (chord) begin m_hold[k] = 3; nx = 0; end
          else if (pu) begin m_hold[k] = 1; nx = up_of(old, p_wrap[k]); m_p[k] = cyc; end
          else if (pd) begin m_hold[k] = 2; nx = dn_of(old, p_wrap[k]); m_p[k] = cyc; end
        end
        1, 2: begin
          if (lk) m_hold[k] = 0;
          else if (chord) begin m_hold[k] = 3; nx = 0; end
          else if (!lvl[m_hold[k] - 1]) begin
            if (pu) begin m_hold[k] = 1; nx = up_of(old, p_wrap[k]); m_p[k] = cyc; end
            else if (pd) begin m_hold[k] = 2; nx = dn_of(old, p_wrap[k]); m_p[k] = cyc; end
            else m_hold[k] = 0;
          end else if (p_rd[k] > 0) begin
            d = cyc - m_p[k];
            if (d == p_rd[k] || (d > p_rd[k] && (d - p_rd[k]) % RR == 0))
              nx = (m_hold[k] == 1) ? up_of(old, p_wrap[k]) : dn_of(old, p_wrap[k]);
          end
        end
        default: if (!lvl[0] && !lvl[1]) m_hold[k] = 0;
      endcase
      m_chg[k]  = (nx != old);
      m_mode[k] = nx;
    end
    hist_u.push_back(s2[0]);
    if (hist_u.size() > DEB) void'(hist_u.pop_front());
    hist_d.push_back(s2[1]);
    if (hist_d.size() > DEB) void'(hist_d.pop_front());
    db_old[0] = lvl[0];
    db_old[1] = lvl[1];
    db_cur[0] = deb_next(lvl[0], hist_u);
    db_cur[1] = deb_next(lvl[1], hist_d);
    s2[0] = s1[0]; s2[1] = s1[1];
    s1[0] = btn_up; s1[1] = btn_dwn;
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) model_reset();
    else model_edge();
  end

  task automatic tick();
    @(negedge clk);
    chk("mode_sat", 32'(mode_b), m_mode[0]);
    chk("mode_wrap", 32'(mode_w), m_mode[1]);
    chk("mode_rpt", 32'(mode_r), m_mode[2]);
    chk("chg_sat", 32'(chg_b), 32'(m_chg[0]));
    chk("chg_wrap", 32'(chg_w), 32'(m_chg[1]));
    chk("chg_rpt", 32'(chg_r), 32'(m_chg[2]));
    chk("locked", 32'({lk_b, lk_w, lk_r}), (start | ~idle) ? 32'd7 : 32'd0);
    chk("range", 32'({mode_b < 3'd5, mode_w < 3'd5, mode_r < 3'd5}), 32'd7);
    if (chg_b) pulses = pulses + 1;
    if (chg_r) rpt_log.push_back(cyc);
  endtask

  task automatic do_reset();
    btn_up = 0; btn_dwn = 0; start = 0; idle = 1;
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic press(input bit up, input bit dn);
    btn_up = up; btn_dwn = dn;
    repeat (5) tick();
    btn_up = 0; btn_dwn = 0;
    repeat (6) tick();
  endtask

  int sat_up[6]  = '{1, 2, 3, 4, 4, 4};
  int sat_dn[6]  = '{3, 2, 1, 0, 0, 0};
  int sat_pl[6]  = '{1, 1, 1, 1, 0, 0};
  int rpt_at[4]  = '{4, 12, 16, 20};

  initial begin
    rst = 1; start = 0; idle = 1; btn_up = 0; btn_dwn = 0;
    tick(); tick();
    rst = 0;
    tick();
    chk("reset_mode", 32'(mode_b), 0);
    chk("reset_chg", 32'(chg_b), 0);

    // Debounce latency: first sampling edge is the next posedge.
    btn_up = 1;
    repeat (4) tick();
    chk("deb_early", 32'(mode_b), 0);
    tick();
    chk("deb_mode", 32'(mode_b), 1);
    chk("deb_pulse", 32'(chg_b), 1);
    tick();
    btn_up = 0;
    repeat (8) tick();
    chk("deb_hold", 32'(mode_b), 1);
    btn_up = 1;
    tick();
    btn_up = 0;
    repeat (8) tick();
    chk("glitch", 32'(mode_b), 1);

    // Saturation at both ends.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pulses = 0;
      press(1, 0);
      chk("sat_up", 32'(mode_b), sat_up[i]);
      chk("sat_up_pulse", pulses, sat_pl[i]);
    end
    for (int i = 0; i < 6; i++) begin
      pulses = 0;
      press(0, 1);
      chk("sat_dn", 32'(mode_b), sat_dn[i]);
      chk("sat_dn_pulse", pulses, sat_pl[i]);
    end

    // Wrap instance against saturating instance.
    do_reset();
    repeat (4) press(1, 0);
    chk("wrap_top", 32'(mode_w), 4);
    press(1, 0);
    chk("wrap_up", 32'(mode_w), 0);
    chk("sat_top", 32'(mode_b), 4);
    press(0, 1);
    chk("wrap_dn", 32'(mode_w), 4);

    // Lock: presses dropped, held button across unlock gives no step.
    do_reset();
    start = 1;
    repeat (3) press(1, 0);
    chk("lock_mode", 32'(mode_b), 0);
    chk("lock_out", 32'(lk_b), 1);
    btn_up = 1;
    repeat (8) tick();
    start = 0;
    repeat (8) tick();
    chk("lock_held", 32'(mode_b), 0);
    btn_up = 0;
    repeat (6) tick();
    press(1, 0);
    chk("lock_after", 32'(mode_b), 1);

    // Auto-repeat timing on the repeat instance.
    do_reset();
    rpt_log.delete();
    btn_up = 1;
    t0 = cyc + 1;
    repeat (40) tick();
    btn_up = 0;
    repeat (6) tick();
    chk("rpt_count", rpt_log.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("rpt_edge", (i < rpt_log.size()) ? rpt_log[i] - t0 : -1, rpt_at[i]);
    chk("rpt_mode", 32'(mode_r), 4);
    chk("rpt_off", 32'(mode_b), 1);

    // Chord back to home, then reset in the middle of a hold.
    do_reset();
    repeat (3) press(1, 0);
    chk("chord_pre", 32'(mode_b), 3);
    pulses = 0;
    btn_up = 1; btn_dwn = 1;
    repeat (10) tick();
    chk("chord_mode", 32'(mode_b), 0);
    chk("chord_pulse", pulses, 1);
    btn_up = 0; btn_dwn = 0;
    repeat (6) tick();
    press(1, 0);
    chk("chord_after", 32'(mode_b), 1);
    btn_up = 1;
    repeat (5) tick();
    chk("pre_rst", 32'(mode_b), 2);
    rst = 1;
    tick();
    chk("rst_mid", 32'(mode_b), 0);
    rst = 0;
    repeat (6) tick();
    chk("rst_held", 32'(mode_b), 1);
    btn_up = 0;
    repeat (6) tick();

    // Randomised segments against the model.
    for (int i = 0; i < 300; i++) begin
      btn_up  = ($urandom_range(0, 2) == 0);
      btn_dwn = ($urandom_range(0, 2) == 0);
      start   = ($urandom_range(0, 7) == 0);
      idle    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1;
        tick();
        rst = 0;
      end
      repeat ($urandom_range(1, 12)) tick();
    end
    btn_up = 0; btn_dwn = 0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
